// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared synth constants and decoder state type
package synth_pkg;

  localparam int SAMPLE_W   = 8;
  localparam int PWM_PERIOD = 256;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } dec_state_t;

endpackage

// File: rtl/pwm_edge_det.sv
// rtl/pwm_edge_det.sv - input register and rising-edge detect for the PWM line
module pwm_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic q_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      q_q    <= d_i;
      prev_q <= q_q;
    end
  end

  assign q_o    = q_q;
  assign rise_o = q_q & ~prev_q;

endmodule

// File: rtl/pwm_sample_decoder.sv
// rtl/pwm_sample_decoder.sv - recovers PWM samples by counting high time per frame
module pwm_sample_decoder
  import synth_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_W,
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_i,
  output logic [WIDTH-1:0] sample_o,
  output logic             sample_valid_o,
  output logic             locked_o,
  output logic             phase_err_o
);

  localparam int               PW       = $clog2(PERIOD);
  localparam logic [PW-1:0]    POS_LAST = PW'(PERIOD - 1);
  localparam logic [WIDTH:0]   HFULL    = (WIDTH + 1)'(PERIOD);
  localparam logic [WIDTH-1:0] SMAX     = '1;

  logic q;
  logic rise;

  dec_state_t       state_q;
  logic [PW-1:0]    pos_q;
  logic [WIDTH:0]   hcnt_q;
  logic [WIDTH-1:0] sample_q;
  logic             valid_q;
  logic             locked_q;
  logic             err_q;

  logic [WIDTH:0]   hcnt_d;
  logic [WIDTH:0]   hcnt_reload;
  logic [WIDTH-1:0] sample_d;

  pwm_edge_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pwm_i),
    .q_o    (q),
    .rise_o (rise)
  );

  assign hcnt_d      = hcnt_q + {{WIDTH{1'b0}}, q};
  assign hcnt_reload = {{WIDTH{1'b0}}, q};
  // A line that never went low in the frame counts PERIOD, one above the top code.
  assign sample_d    = (hcnt_q > {1'b0, SMAX}) ? SMAX : hcnt_q[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      hcnt_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (!en) begin
        state_q  <= IDLE;
        pos_q    <= '0;
        hcnt_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= ACQUIRE;
              pos_q   <= '0;
              hcnt_q  <= hcnt_reload;
            end
          end
          ACQUIRE, LOCKED: begin
            if (pos_q == POS_LAST) begin
              // Frame end: emit, and start the next frame whether or not a rise is present.
              sample_q <= sample_d;
              valid_q  <= 1'b1;
              pos_q    <= '0;
              hcnt_q   <= hcnt_reload;
              if (hcnt_q == HFULL) begin
                err_q <= 1'b1;
              end else begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else if (rise) begin
              err_q    <= 1'b1;
              state_q  <= ACQUIRE;
              locked_q <= 1'b0;
              pos_q    <= '0;
              hcnt_q   <= hcnt_reload;
            end else begin
              pos_q  <= pos_q + PW'(1);
              hcnt_q <= hcnt_d;
            end
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign locked_o       = locked_q;
  assign phase_err_o    = err_q;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// tb/tb_pwm_sample_decoder.sv - self-checking bench for pwm_sample_decoder
module tb_pwm_sample_decoder;

  localparam int P = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       pwm_i = 1'b0;
  logic [7:0] sample_o;
  logic       sample_valid_o;
  logic       locked_o;
  logic       phase_err_o;

  always #5 clk = ~clk;

  pwm_sample_decoder #(.WIDTH(8), .PERIOD(P)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .pwm_i          (pwm_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .locked_o       (locked_o),
    .phase_err_o    (phase_err_o)
  );

  typedef struct {
    int s;
    int exp_s;
    int exp_e;
  } vec_t;

  typedef struct {
    int t;
    int v;
    int e;
    int l;
    int s;
  } ev_t;

  int   n_checks = 0;
  int   n_fails = 0;
  int   hist[$];
  ev_t  ev[$];
  int   t = 0;
  int   lr = -1;
  int   m_state = 0;
  int   m_ts = 0;
  int   m_sample = 0;
  int   m_valid = 0;
  int   m_err = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // q as the decoder sees it at edge k: the line sampled one edge earlier, zero across a reset
  function automatic int qs(input int k);
    if (k < 1 || k - 1 <= lr) return 0;
    return hist[k-1];
  endfunction

  function automatic int rise_at(input int k);
    return (qs(k) == 1 && qs(k - 1) == 0) ? 1 : 0;
  endfunction

  // Reference: frame start edge m_ts, frame ends PERIOD edges later, high time summed from history.
  task automatic model_step(input bit e, input bit r);
    int h;
    m_valid = 0;
    m_err   = 0;
    if (r) begin
      m_state  = 0;
      m_sample = 0;
      lr       = t;
    end else if (!e) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (rise_at(t) == 1) begin
        m_state = 1;
        m_ts    = t;
      end
    end else if (t == m_ts + P) begin
      h = 0;
      for (int k = m_ts; k < t; k++) h += qs(k);
      m_valid  = 1;
      m_sample = (h > 255) ? 255 : h;
      if (h == P) m_err = 1;
      else m_state = 2;
      m_ts = t;
    end else if (rise_at(t) == 1) begin
      m_err   = 1;
      m_state = 1;
      m_ts    = t;
    end
  endtask

  task automatic step(input bit p, input bit e, input bit r);
    int got_l;
    pwm_i = p;
    en    = e;
    reset = r;
    hist.push_back(int'(p));
    model_step(e, r);
    @(posedge clk);
    #1;
    got_l = int'(locked_o);
    n_checks++;
    if (int'(sample_o) != m_sample || int'(sample_valid_o) != m_valid ||
        got_l != ((m_state == 2) ? 1 : 0) || int'(phase_err_o) != m_err) begin
      n_fails++;
      $display("FAIL model cycle %0d: got s=%0d v=%0d l=%0d e=%0d expected s=%0d v=%0d l=%0d e=%0d",
               t, sample_o, sample_valid_o, locked_o, phase_err_o,
               m_sample, m_valid, (m_state == 2) ? 1 : 0, m_err);
    end
    if (sample_valid_o || phase_err_o)
      ev.push_back('{t, int'(sample_valid_o), int'(phase_err_o), got_l, int'(sample_o)});
    t++;
  endtask

  task automatic frame(input int s, input int len, input bit e);
    for (int i = 0; i < len; i++) step(i < s, e, 1'b0);
  endtask

  function automatic int ev_at(input int tt);
    for (int i = 0; i < ev.size(); i++) if (ev[i].t == tt) return i;
    return -1;
  endfunction

  task automatic expect_ev(input string name, input int tt, input int s, input int v,
                           input int e, input int l);
    int idx;
    idx = ev_at(tt);
    chk({name, " present"}, (idx >= 0) ? 1 : 0, 1);
    if (idx >= 0) begin
      chk({name, " sample"}, ev[idx].s, s);
      chk({name, " valid"}, ev[idx].v, v);
      chk({name, " err"}, ev[idx].e, e);
      chk({name, " locked"}, ev[idx].l, l);
    end
  endtask

  vec_t tbl[9];

  initial begin
    int t_hi;
    int t_inj;
    int t_h;
    int t_r;
    int n_err;

    tbl[0] = '{128, 128, 0};
    tbl[1] = '{0,   0,   0};
    tbl[2] = '{1,   1,   0};
    tbl[3] = '{255, 255, 0};
    tbl[4] = '{0,   0,   0};
    tbl[5] = '{256, 255, 1};
    tbl[6] = '{10,  10,  0};
    tbl[7] = '{200, 200, 0};
    tbl[8] = '{3,   3,   0};

    repeat (3) step(1'b0, 1'b0, 1'b1);
    chk("reset sample", int'(sample_o), 0);
    chk("reset valid", int'(sample_valid_o), 0);
    chk("reset locked", int'(locked_o), 0);
    chk("reset err", int'(phase_err_o), 0);

    // First lock and latency
    repeat (10) step(1'b0, 1'b1, 1'b0);
    ev.delete();
    t_hi = t;
    repeat (3) frame(128, P, 1'b1);
    expect_ev("first strobe", t_hi + P + 1, 128, 1, 0, 1);
    chk("strobes before first", (ev.size() > 0) ? ev[0].t : -1, t_hi + P + 1);
    expect_ev("second strobe", t_hi + 2 * P + 1, 128, 1, 0, 1);

    // Table of frames while locked
    ev.delete();
    for (int i = 0; i < 9; i++) frame(tbl[i].s, P, 1'b1);
    frame(0, P, 1'b1);
    chk("table strobe count", ev.size(), 10);
    for (int i = 0; i < 9; i++) begin
      if (i + 1 < ev.size()) begin
        chk($sformatf("table[%0d] sample", i), ev[i+1].s, tbl[i].exp_s);
        chk($sformatf("table[%0d] err", i), ev[i+1].e, tbl[i].exp_e);
        chk($sformatf("table[%0d] locked", i), ev[i+1].l, 1);
        chk($sformatf("table[%0d] spacing", i), ev[i+1].t - ev[i].t, P);
      end
    end

    // Misaligned rise while locked
    ev.delete();
    frame(40, 100, 1'b1);
    t_inj = t;
    frame(40, P, 1'b1);
    frame(40, P, 1'b1);
    expect_ev("inject err", t_inj + 1, 0, 0, 1, 0);
    expect_ev("inject relock", t_inj + P + 1, 40, 1, 0, 1);
    n_err = 0;
    for (int i = 0; i < ev.size(); i++)
      if (ev[i].t > t_inj + 1 && ev[i].t < t_inj + P + 1) n_err++;
    chk("inject no strobe in discarded frame", n_err, 0);

    // Line stuck high
    ev.delete();
    t_h = t;
    repeat (600) step(1'b1, 1'b1, 1'b0);
    repeat (168) step(1'b0, 1'b1, 1'b0);
    frame(60, P, 1'b1);
    frame(60, P, 1'b1);
    expect_ev("stuck high 1", t_h + P + 1, 255, 1, 1, 1);
    expect_ev("stuck high 2", t_h + 2 * P + 1, 255, 1, 1, 1);
    expect_ev("stuck high tail", t_h + 3 * P + 1, 88, 1, 0, 1);

    // Reset mid-frame
    repeat (50) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("midreset sample", int'(sample_o), 0);
    chk("midreset valid", int'(sample_valid_o), 0);
    chk("midreset locked", int'(locked_o), 0);
    chk("midreset err", int'(phase_err_o), 0);
    ev.delete();
    repeat (30) step(1'b0, 1'b1, 1'b0);
    chk("after reset quiet", ev.size(), 0);
    t_hi = t;
    repeat (3) frame(90, P, 1'b1);
    chk("after reset first strobe", (ev.size() > 0) ? ev[0].t : -1, t_hi + P + 1);
    expect_ev("after reset strobe", t_hi + P + 1, 90, 1, 0, 1);

    // Enable dropped mid-frame
    for (int i = 0; i < 30; i++) step(i < 90, 1'b1, 1'b0);
    ev.delete();
    step(1'b1, 1'b0, 1'b0);
    chk("en drop locked", int'(locked_o), 0);
    chk("en drop sample hold", int'(sample_o), 90);
    for (int i = 31; i < P; i++) step(i < 90, 1'b0, 1'b0);
    frame(90, P, 1'b0);
    chk("disabled sample hold", int'(sample_o), 90);
    for (int i = 0; i < P; i++) step(i < 90, i >= 40, 1'b0);
    t_r = t;
    frame(90, P, 1'b1);
    frame(90, P, 1'b1);
    chk("reenable strobe count", ev.size(), 1);
    expect_ev("reenable strobe", t_r + P + 1, 90, 1, 0, 1);

    // Random frames, short frames, enable drops and stray resets
    for (int f = 0; f < 40; f++) begin
      int s;
      int len;
      bit e;
      s   = $urandom_range(0, 256);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 255) : P;
      e   = ($urandom_range(0, 14) != 0);
      for (int i = 0; i < len; i++) step(i < s, e, $urandom_range(0, 999) == 0);
    end
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) == 0, $urandom_range(0, 49) != 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
